regfile_2r2w: RTL

Parametrised multi-port register file for the pipelined datapath. It provides two combinational read ports and two write ports on the rising clock edge, with optional write-to-read bypass and an optional hardwired zero register. It also has a sequential soft-clear engine that zeroes the array one entry per cycle without asserting reset. It sits between decode (reads) and writeback (writes).

---
 rtl/regfile_2r2w.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_2r2w.sv
// rtl/regfile_2r2w.sv - two-read/two-write register file with bypass, zero register and soft-clear sweep
module regfile_2r2w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr0_ok, wr1_ok;
    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rd [2];

    assign busy     = (state_q == CLEAR);
    assign clr_done = done_q;

    assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // The sweep ends on the entry whose pointer is all ones; ptr then wraps back to 0.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port 1 is assigned last so it wins an address conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (busy) begin
            mem[ptr_q] <= '0;
        end else begin
            if (wr0_ok) mem[waddr0] <= wdata0;
            if (wr1_ok) mem[waddr1] <= wdata1;
        end
    end

    assign ra[0] = raddr0;
    assign ra[1] = raddr1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = mem[ra[p]];
            if ((ZERO_REG != 0) && (ra[p] == '0))
                rd[p] = '0;
            else if (busy)
                rd[p] = '0;
            else if ((BYPASS != 0) && we1 && (waddr1 == ra[p]))
                rd[p] = wdata1;
            else if ((BYPASS != 0) && we0 && (waddr0 == ra[p]))
                rd[p] = wdata0;
        end
    end

    assign rdata0 = rd[0];
    assign rdata1 = rd[1];
endmodule
